// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: shared state type, counter sizing and width limits for the serializer
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  // Bits needed to index 0..n-1, never less than one so a counter always exists.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/piso_serializer_shift_reg_load.sv
// shift_reg_load: loadable shift register presenting its top bit, zero-filled from below
module shift_reg_load
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // A load replaces the whole word; otherwise move one place toward the top and pull in a zero.
  always_comb sr_d = load_i ? data_i : {sr_q[WIDTH-2:0], 1'b0};

  // Register advances only on enabled clocks; reset clears it regardless of enable.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) sr_q <= '0;
    else if (ce_i) sr_q <= sr_d;
  end

  assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready word intake, serial bit output with OVALID/FIRST/LAST framing
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             CE,
  input  logic [WIDTH-1:0] DATA,
  input  logic             VALID,
  output logic             READY,
  output logic             O,
  output logic             OVALID,
  output logic             FIRST,
  output logic             LAST
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("piso_serializer: WIDTH out of range");
  end

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            ovalid_q;
  logic            first_q;
  logic            last_q;
  logic [WIDTH-1:0] word;
  logic            last_bit;
  logic            load;

  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_IDX);
  assign READY    = CE && ((state_q == IDLE) || last_bit);
  assign load     = VALID && READY;
  assign cnt_d    = cnt_q + CW'(1);

  // The shifter always emits its top bit, so LSB-first words are mirrored on the way in.
  always_comb begin
    word = '0;
    for (int i = 0; i < WIDTH; i++) word[i] = MSB_FIRST ? DATA[i] : DATA[WIDTH-1-i];
  end

  shift_reg_load #(.WIDTH(WIDTH)) u_sr (
    .clk_i (CLK),
    .rst_ni(RESETN),
    .ce_i  (CE),
    .load_i(load),
    .data_i(word),
    .msb_o (O)
  );

  // Frame sequencer: a load (also on the last bit) restarts the frame, otherwise count to the end then idle.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ovalid_q <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else if (CE) begin
      if (load) begin
        state_q  <= SHIFT;
        cnt_q    <= '0;
        ovalid_q <= 1'b1;
        first_q  <= 1'b1;
        last_q   <= 1'b0;
      end else if (last_bit) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        ovalid_q <= 1'b0;
        first_q  <= 1'b0;
        last_q   <= 1'b0;
      end else if (state_q == SHIFT) begin
        cnt_q   <= cnt_d;
        first_q <= 1'b0;
        last_q  <= (cnt_d == LAST_IDX);
      end
    end
  end

  assign OVALID = ovalid_q;
  assign FIRST  = first_q;
  assign LAST   = last_q;

endmodule
